prog_sequencer: RTL and testbench

- Program sequencer that autonomously feeds the 9-bit mini-processor from a synchronous instruction ROM.
- Prefetches words into a 2-entry buffer and tracks the processor's T0–T3 time step from its Done output.
- Drives the processor's data input with the instruction word at T0 and the immediate word at T1 of mvi.
- Drives a NOP (mv R0,R0 = 9'b000000000) whenever no complete instruction is ready, and stops on a HALT word (opcode 111).

---
 rtl/prog_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_prog_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// Program sequencer: prefetches instruction words from a synchronous ROM into a
// two-entry buffer, tracks the mini-processor's T0-T3 step from its Done output
// and presents each instruction (and the mvi immediate) on the processor's DIN.
module prog_sequencer #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [8:0]        mem_data,
  output logic [8:0]        proc_din,
  output logic              proc_run,
  input  logic              proc_done,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b111;

  // Buffer entries hold {immediate tag, 9-bit word}; entry 0 is the head.
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [9:0]        buf0_q, buf0_d;
  logic [9:0]        buf1_q, buf1_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic              immNext_q, immNext_d;
  logic              haltPending_q, haltPending_d;
  logic              immIssue_q, immIssue_d;
  logic [1:0]        phase_q, phase_d;
  logic [8:0]        din_q, din_d;
  logic              run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       isBusy;
  logic       retIsHalt;
  logic       fetchEn;
  logic       push;
  logic       pop;
  logic       headMvi;
  logic       canIssue;
  logic [9:0] pushEntry;

  assign isBusy    = (state_q == RUN) || (state_q == DRAIN);
  assign phase_d   = proc_done ? 2'd0 : phase_q + 2'd1;

  // A returning non-immediate word with opcode 111 ends the program; the read
  // behind it is suppressed so nothing past the HALT word is ever addressed.
  assign retIsHalt = inflight_q && !haltPending_q && !immNext_q && (mem_data[8:6] == OP_HALT);
  assign fetchEn   = isBusy && !haltPending_q && !retIsHalt
                     && ((count_q + {1'b0, inflight_q}) < 2'd2);
  assign push      = inflight_q && isBusy && !haltPending_q && !retIsHalt;
  assign pushEntry = {immNext_q, mem_data};

  assign headMvi   = !buf0_q[9] && (buf0_q[8:6] == OP_MVI);
  assign canIssue  = (count_q != 2'd0) && !buf0_q[9] && (!headMvi || (count_q == 2'd2));

  assign mem_rd      = fetchEn;
  assign mem_addr    = fetchEn ? pc_q : '0;
  assign proc_din    = din_q;
  assign proc_run    = run_q;
  assign busy        = isBusy;
  assign halted      = (state_q == HALTED);
  assign instr_count = cnt_q;

  // Next-state logic: fetch, buffer push/pop, issue decision and FSM transitions.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    count_d       = count_q;
    inflight_d    = fetchEn;
    immNext_d     = immNext_q;
    haltPending_d = haltPending_q;
    immIssue_d    = 1'b0;
    din_d         = 9'd0;
    run_d         = 1'b0;
    cnt_d         = cnt_q;
    pop           = 1'b0;

    if (isBusy) begin
      if (immIssue_q) begin
        din_d = buf0_q[8:0];
        pop   = 1'b1;
      end else if ((phase_d == 2'd0) && canIssue) begin
        din_d      = buf0_q[8:0];
        pop        = 1'b1;
        run_d      = 1'b1;
        immIssue_d = headMvi;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (pop) begin
      buf0_d  = buf1_q;
      count_d = count_q - 2'd1;
    end

    if (push) begin
      if (count_d == 2'd0) begin
        buf0_d = pushEntry;
      end else begin
        buf1_d = pushEntry;
      end
      count_d = count_d + 2'd1;
      if (immNext_q) begin
        immNext_d = 1'b0;
      end else begin
        immNext_d = (mem_data[8:6] == OP_MVI);
      end
    end

    if (fetchEn) begin
      pc_d = pc_q + 1'b1;
    end

    if (retIsHalt && (state_q == RUN)) begin
      haltPending_d = 1'b1;
      state_d       = DRAIN;
    end

    if ((state_q == DRAIN) && (count_q == 2'd0) && !immIssue_q && (phase_d == 2'd0)) begin
      state_d = HALTED;
    end

    if (((state_q == IDLE) || (state_q == HALTED)) && Start) begin
      state_d       = RUN;
      pc_d          = '0;
      count_d       = 2'd0;
      inflight_d    = 1'b0;
      immNext_d     = 1'b0;
      haltPending_d = 1'b0;
      immIssue_d    = 1'b0;
      cnt_d         = '0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      buf0_q        <= '0;
      buf1_q        <= '0;
      count_q       <= 2'd0;
      inflight_q    <= 1'b0;
      immNext_q     <= 1'b0;
      haltPending_q <= 1'b0;
      immIssue_q    <= 1'b0;
      phase_q       <= 2'd0;
      din_q         <= 9'd0;
      run_q         <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      buf0_q        <= buf0_d;
      buf1_q        <= buf1_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      immNext_q     <= immNext_d;
      haltPending_q <= haltPending_d;
      immIssue_q    <= immIssue_d;
      phase_q       <= phase_d;
      din_q         <= din_d;
      run_q         <= run_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Testbench for prog_sequencer: a behavioural ROM and mini-processor close the
// loop; a scoreboard queue holds the words expected on proc_din in issue order.
module tb_prog_sequencer;

  localparam int ADDR_W = 5;
  localparam int CNT_W  = 8;

  logic              Clock;
  logic              Resetn;
  logic              Start;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0]        mem_data;
  logic [8:0]        proc_din;
  logic              proc_run;
  logic              proc_done;
  logic              busy;
  logic              halted;
  logic [CNT_W-1:0]  instr_count;

  prog_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Start(Start),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .proc_din(proc_din),
    .proc_run(proc_run),
    .proc_done(proc_done),
    .busy(busy),
    .halted(halted),
    .instr_count(instr_count)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] rom [0:31];
  logic [8:0] regs [0:7];
  logic [8:0] ir, aReg, gReg;
  logic [1:0] pPhase;

  logic [8:0] expQ [$];
  logic [8:0] monExp;
  logic       immPend = 1'b0;
  int         runCount = 0;
  int         maxAddr = 0;
  int         lastRdAddr = -1;
  logic       wrapSeen = 1'b0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous ROM: word for the address presented in one cycle appears in the next.
  always @(posedge Clock) mem_data <= rom[mem_addr];

  // Mini-processor Done: mv/mvi finish at T1, add/sub at T3, other opcodes never.
  always_comb begin
    proc_done = ((pPhase == 2'd1) && ((ir[8:6] == 3'b000) || (ir[8:6] == 3'b001)))
             || ((pPhase == 2'd3) && ((ir[8:6] == 3'b010) || (ir[8:6] == 3'b011)));
  end

  // Mini-processor datapath and time-step counter.
  always @(posedge Clock) begin
    if (!Resetn) begin
      pPhase <= 2'd0;
      ir     <= 9'd0;
      aReg   <= 9'd0;
      gReg   <= 9'd0;
      for (int r = 0; r < 8; r++) regs[r] <= 9'd0;
    end else begin
      case (pPhase)
        2'd0: ir <= proc_din;
        2'd1: begin
          if (ir[8:6] == 3'b000) regs[ir[5:3]] <= regs[ir[2:0]];
          else if (ir[8:6] == 3'b001) regs[ir[5:3]] <= proc_din;
          else aReg <= regs[ir[5:3]];
        end
        2'd2: gReg <= (ir[8:6] == 3'b011) ? aReg - regs[ir[2:0]] : aReg + regs[ir[2:0]];
        default: if ((ir[8:6] == 3'b010) || (ir[8:6] == 3'b011)) regs[ir[5:3]] <= gReg;
      endcase
      pPhase <= proc_done ? 2'd0 : pPhase + 2'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every issued word and checks NOP cycles are zero.
  always @(negedge Clock) begin
    if (!Resetn) begin
      expQ.delete();
      immPend = 1'b0;
    end else begin
      if (mem_rd) begin
        if (int'(mem_addr) > maxAddr) maxAddr = int'(mem_addr);
        if ((lastRdAddr == 31) && (mem_addr == 5'd0)) wrapSeen = 1'b1;
        lastRdAddr = int'(mem_addr);
      end
      if (immPend) begin
        immPend = 1'b0;
        if (expQ.size() == 0) begin
          checkOutput("imm_underflow", 32'(expQ.size()), 32'd1);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("immediate", 32'(proc_din), 32'(monExp));
          checkOutput("imm_run_low", 32'(proc_run), 32'd0);
        end
      end else if (proc_run) begin
        runCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_issue", 32'(proc_din), 32'h1ff);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("issue", 32'(proc_din), 32'(monExp));
          if (monExp[8:6] == 3'b001) immPend = 1'b1;
        end
      end else begin
        checkOutput("nop_din", 32'(proc_din), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic applyStimulus();
    maxAddr    = 0;
    lastRdAddr = -1;
    wrapSeen   = 1'b0;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
  endtask

  task automatic fillRom(input logic [8:0] w);
    for (int a = 0; a < 32; a++) rom[a] = w;
  endtask

  task automatic waitHalted(input int bound, input string tag);
    int n = 0;
    while (!halted && (n < bound)) begin
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(halted), 32'd1);
  endtask

  initial begin
    int n;
    int cntBefore;
    int runBefore;
    Resetn = 1'b0;
    Start  = 1'b0;
    fillRom(9'h000);
    tick(3);

    // Reset state
    checkOutput("rst_din", 32'(proc_din), 32'd0);
    checkOutput("rst_run", 32'(proc_run), 32'd0);
    checkOutput("rst_mem_rd", 32'(mem_rd), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_count", 32'(instr_count), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    Resetn = 1'b1;
    tick(4);

    // Test 1: mvi R0,5 ; add R0,R0 ; HALT
    $display("[TB] test 1: basic program");
    fillRom(9'h1C0);
    rom[0] = 9'h040; rom[1] = 9'h005; rom[2] = 9'h080; rom[3] = 9'h1C0;
    expQ.push_back(9'h040); expQ.push_back(9'h005); expQ.push_back(9'h080);
    applyStimulus();
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitHalted(80, "t1_halted");
    checkOutput("t1_count", 32'(instr_count), 32'd2);
    checkOutput("t1_r0", 32'(regs[0]), 32'd10);
    checkOutput("t1_max_addr", 32'(maxAddr), 32'd3);
    checkOutput("t1_queue_left", 32'(expQ.size()), 32'd0);
    tick(4);

    // Test 2: reset during the add's T2 step
    $display("[TB] test 2: reset mid-run");
    expQ.push_back(9'h040); expQ.push_back(9'h005); expQ.push_back(9'h080);
    applyStimulus();
    n = 0;
    while (!(proc_run && (proc_din == 9'h080)) && (n < 80)) begin
      tick(1);
      n++;
    end
    checkOutput("t2_add_issued", 32'(proc_din), 32'h080);
    tick(2);
    Resetn = 1'b0;
    tick(1);
    Resetn = 1'b1;
    checkOutput("t2_din", 32'(proc_din), 32'd0);
    checkOutput("t2_busy", 32'(busy), 32'd0);
    checkOutput("t2_halted", 32'(halted), 32'd0);
    checkOutput("t2_count", 32'(instr_count), 32'd0);
    checkOutput("t2_mem_rd", 32'(mem_rd), 32'd0);
    runBefore = runCount;
    tick(8);
    checkOutput("t2_no_issue", 32'(runCount - runBefore), 32'd0);
    checkOutput("t2_still_idle", 32'(busy), 32'd0);

    // Test 3: mvi at the top address, its immediate wrapped to address 0
    $display("[TB] test 3: wrap of mvi immediate");
    fillRom(9'h008);
    rom[0]  = 9'h001;
    rom[31] = 9'h050;
    expQ.push_back(9'h001);
    for (int a = 1; a < 31; a++) expQ.push_back(9'h008);
    expQ.push_back(9'h050);
    expQ.push_back(9'h001);
    applyStimulus();
    n = 0;
    while (!(mem_rd && (mem_addr == 5'd5)) && (n < 80)) begin
      tick(1);
      n++;
    end
    rom[1] = 9'h1C0;
    waitHalted(300, "t3_halted");
    checkOutput("t3_count", 32'(instr_count), 32'd32);
    checkOutput("t3_r2", 32'(regs[2]), 32'd1);
    checkOutput("t3_wrap", 32'(wrapSeen), 32'd1);
    checkOutput("t3_queue_left", 32'(expQ.size()), 32'd0);
    tick(4);

    // Test 4: Start while busy is ignored
    $display("[TB] test 4: start while busy");
    fillRom(9'h1C0);
    for (int a = 0; a < 10; a++) begin
      rom[a] = 9'h008;
      expQ.push_back(9'h008);
    end
    applyStimulus();
    tick(8);
    cntBefore = int'(instr_count);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(1);
    checkOutput("t4_busy", 32'(busy), 32'd1);
    checkOutput("t4_count_kept", 32'(int'(instr_count) >= cntBefore && cntBefore > 0), 32'd1);
    waitHalted(120, "t4_halted");
    checkOutput("t4_count", 32'(instr_count), 32'd10);
    checkOutput("t4_max_addr", 32'(maxAddr), 32'd10);
    checkOutput("t4_queue_left", 32'(expQ.size()), 32'd0);
    tick(4);

    // Test 5: HALT at address 0
    $display("[TB] test 5: immediate halt");
    fillRom(9'h1C0);
    runBefore = runCount;
    applyStimulus();
    waitHalted(4, "t5_halted_fast");
    checkOutput("t5_count", 32'(instr_count), 32'd0);
    tick(4);
    checkOutput("t5_no_run", 32'(runCount - runBefore), 32'd0);

    // Test 6: endless mv stream, counter saturation and PC wrap
    $display("[TB] test 6: saturation");
    fillRom(9'h008);
    for (int k = 0; k < 400; k++) expQ.push_back(9'h008);
    applyStimulus();
    n = 0;
    while ((instr_count != 8'hFF) && (n < 1500)) begin
      tick(1);
      n++;
    end
    checkOutput("t6_reach_255", 32'(instr_count), 32'd255);
    runBefore = runCount;
    tick(20);
    checkOutput("t6_saturated", 32'(instr_count), 32'd255);
    checkOutput("t6_still_issuing", 32'(runCount > runBefore), 32'd1);
    checkOutput("t6_busy", 32'(busy), 32'd1);
    checkOutput("t6_wrap", 32'(wrapSeen), 32'd1);
    Resetn = 1'b0;
    tick(2);
    Resetn = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
